// File: rtl/key_speed_pkg.sv
// key_speed_pkg
// Shared definitions for the key-driven speed controller.
//   LVL_W           : width of the speed level
//   lvl_t           : speed level type (0..3)
//   CNT_MAX_L0..L3  : LED period terminal counts per level
//   filt_state_t    : key filter FSM state encoding
//   cnt_max_of()    : level -> terminal count lookup
package key_speed_pkg;

  localparam int LVL_W = 2;
  typedef logic [LVL_W-1:0] lvl_t;

  localparam lvl_t LVL_MIN = '0;
  localparam lvl_t LVL_MAX = '1;

  localparam logic [15:0] CNT_MAX_L0 = 16'd49_999;
  localparam logic [15:0] CNT_MAX_L1 = 16'd24_999;
  localparam logic [15:0] CNT_MAX_L2 = 16'd12_499;
  localparam logic [15:0] CNT_MAX_L3 = 16'd6_249;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_FILT = 2'd1,
    ST_HELD       = 2'd2,
    ST_REL_FILT   = 2'd3
  } filt_state_t;

  function automatic logic [15:0] cnt_max_of(input lvl_t lvl);
    case (lvl)
      2'd0:    return CNT_MAX_L0;
      2'd1:    return CNT_MAX_L1;
      2'd2:    return CNT_MAX_L2;
      default: return CNT_MAX_L3;
    endcase
  endfunction

endpackage

// File: rtl/key_filter.sv
// key_filter
// Synchronizes one raw active-low key and debounces it; emits a single
// one-cycle pulse when a press has been stable for DEBOUNCE_CNT cycles.
// Releases are debounced the same way but produce no pulse.
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   key_n       : raw asynchronous key, active low
//   press_pulse : one-cycle pulse on an accepted press
module key_filter
  import key_speed_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CNT + 1);
  // Entering a filter state already accounts for one stable cycle, so the
  // transition fires while the counter shows the last of the remaining ones.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             r_sync1;
  logic             r_sync2;
  filt_state_t      r_state;
  filt_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Synchronizers idle at 1 (released) so a key held through reset is seen
  // as a fresh fall once reset lifts.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    press_pulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_sync2) w_state_nxt = ST_PRESS_FILT;
      end
      ST_PRESS_FILT: begin
        if (r_sync2) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
          press_pulse = 1'b1;
        end
      end
      ST_HELD: begin
        w_cnt_nxt = '0;
        if (r_sync2) w_state_nxt = ST_REL_FILT;
      end
      ST_REL_FILT: begin
        if (!r_sync2) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_speed_ctrl.sv
// key_speed_ctrl
// Two debounced buttons step a 4-level speed setting up/down with
// saturation and publish the matching LED period terminal count.
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   key_up      : raw active-low "faster" button
//   key_dn      : raw active-low "slower" button
//   speed_lvl   : current speed level (registered)
//   cnt_max     : terminal count for the downstream LED counter (registered)
//   cnt_max_upd : one-cycle strobe when cnt_max actually changes
module key_speed_ctrl
  import key_speed_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int RESET_LEVEL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_up,
  input  logic             key_dn,
  output logic [LVL_W-1:0] speed_lvl,
  output logic [15:0]      cnt_max,
  output logic             cnt_max_upd
);

  localparam lvl_t RST_LVL = lvl_t'(RESET_LEVEL);

  logic        w_up_pulse;
  logic        w_dn_pulse;
  lvl_t        w_lvl_nxt;
  lvl_t        r_speed_lvl;
  logic [15:0] r_cnt_max;
  logic        r_cnt_max_upd;

  key_filter #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_filt_up (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_up),
    .press_pulse (w_up_pulse)
  );

  key_filter #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_filt_dn (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_dn),
    .press_pulse (w_dn_pulse)
  );

  // Simultaneous up and down pulses cancel out.
  always_comb begin
    w_lvl_nxt = r_speed_lvl;
    case ({w_up_pulse, w_dn_pulse})
      2'b10:   if (r_speed_lvl != LVL_MAX) w_lvl_nxt = r_speed_lvl + 1'b1;
      2'b01:   if (r_speed_lvl != LVL_MIN) w_lvl_nxt = r_speed_lvl - 1'b1;
      default: w_lvl_nxt = r_speed_lvl;
    endcase
  end

  // Level, terminal count and strobe all register on the same edge, which
  // also keeps the outputs free of any combinational path from the keys.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_speed_lvl   <= RST_LVL;
      r_cnt_max     <= cnt_max_of(RST_LVL);
      r_cnt_max_upd <= 1'b0;
    end else begin
      r_speed_lvl   <= w_lvl_nxt;
      r_cnt_max     <= cnt_max_of(w_lvl_nxt);
      r_cnt_max_upd <= (w_lvl_nxt != r_speed_lvl);
    end
  end

  assign speed_lvl   = r_speed_lvl;
  assign cnt_max     = r_cnt_max;
  assign cnt_max_upd = r_cnt_max_upd;

endmodule

// File: tb/tb_key_speed_ctrl.sv
// tb_key_speed_ctrl
// Directed scenarios with hand-computed expectations plus a randomized
// phase, all continuously compared against a behavioural model of the
// key speed controller.
module tb_key_speed_ctrl;

  localparam int D  = 16;
  localparam int RL = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_up = 1'b1;
  logic        key_dn = 1'b1;
  logic [1:0]  speed_lvl;
  logic [15:0] cnt_max;
  logic        cnt_max_upd;

  key_speed_ctrl #(.DEBOUNCE_CNT(D), .RESET_LEVEL(RL)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_up      (key_up),
    .key_dn      (key_dn),
    .speed_lvl   (speed_lvl),
    .cnt_max     (cnt_max),
    .cnt_max_upd (cnt_max_upd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int table_of(input int lvl);
    case (lvl)
      0:       return 49999;
      1:       return 24999;
      2:       return 12499;
      default: return 6249;
    endcase
  endfunction

  // Behavioural model: each key goes through a 2-sample delay; the accepted
  // key level flips once the delayed level has disagreed with it on D+1
  // consecutive edges, and a flip to "pressed" is a press. The level is
  // updated on that same edge.
  int m_s1[2], m_s2[2], m_acc[2], m_run[2];
  int m_lvl   = RL;
  int m_upd   = 0;
  bit m_valid = 1'b0;

  task automatic model_step();
    int raw[2];
    int pulse[2];
    int seen;
    int nl;
    raw[0] = int'(key_up);
    raw[1] = int'(key_dn);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 1; m_s2[k] = 1; m_acc[k] = 1; m_run[k] = 0;
      end
      m_lvl   = RL;
      m_upd   = 0;
      m_valid = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        pulse[k] = 0;
        seen     = m_s2[k];
        m_s2[k]  = m_s1[k];
        m_s1[k]  = raw[k];
        if (seen != m_acc[k]) begin
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_acc[k] = seen;
            m_run[k] = 0;
            if (seen == 0) pulse[k] = 1;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      nl = m_lvl + pulse[0] - pulse[1];
      if (nl > 3) nl = 3;
      if (nl < 0) nl = 0;
      m_upd = (nl != m_lvl) ? 1 : 0;
      m_lvl = nl;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Continuous compare on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("model_lvl", 32'(speed_lvl), m_lvl);
      check("model_cnt_max", 32'(cnt_max), table_of(m_lvl));
      check("model_upd", 32'(cnt_max_upd), m_upd);
    end
  end

  // Accepted-press counters observed on the filter outputs.
  int up_pulses = 0;
  int dn_pulses = 0;
  initial forever begin
    @(negedge clk);
    if (dut.w_up_pulse === 1'b1) up_pulses++;
    if (dut.w_dn_pulse === 1'b1) dn_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance n cycles, counting cnt_max_upd strobes and the last cycle seen.
  task automatic run_count(input int n, output int strobes, output int last);
    strobes = 0;
    last    = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (cnt_max_upd === 1'b1) begin
        strobes++;
        last = i;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; key_up = 1'b1; key_dn = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic up_press(input int hold, input int rel);
    key_up = 1'b0; tick(hold);
    key_up = 1'b1; tick(rel);
  endtask

  int s, at, s2, at2, bounce_s, p0, q0;
  int exp_lvl[4] = '{1, 2, 3, 3};
  int exp_upd[4] = '{1, 1, 1, 0};
  int len_up, len_dn;

  initial begin
    // Reset state and a single clean press.
    do_reset();
    check("rst_lvl", 32'(speed_lvl), 0);
    check("rst_cnt_max", 32'(cnt_max), 49999);
    check("rst_upd", 32'(cnt_max_upd), 0);
    key_up = 1'b0;
    run_count(40, s, at);
    check("clean_strobes", s, 1);
    check("clean_strobe_cycle", at, 19);
    check("clean_lvl", 32'(speed_lvl), 1);
    check("clean_cnt_max", 32'(cnt_max), 24999);
    key_up = 1'b1; tick(30);

    // Bouncing press: four low-5/high-3 bursts, then steady low.
    do_reset();
    bounce_s = 0;
    for (int r = 0; r < 4; r++) begin
      key_up = 1'b0; run_count(5, s, at); bounce_s += s;
      key_up = 1'b1; run_count(3, s, at); bounce_s += s;
    end
    key_up = 1'b0;
    run_count(40, s, at);
    check("bounce_no_upd", bounce_s, 0);
    check("bounce_strobes", s, 1);
    check("bounce_strobe_cycle", at, 19);
    check("bounce_lvl", 32'(speed_lvl), 1);
    key_up = 1'b1; tick(30);

    // Four presses saturate at level 3.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      key_up = 1'b0; run_count(25, s, at);
      key_up = 1'b1; run_count(25, s2, at2);
      check("sat_strobes", s + s2, exp_upd[p]);
      check("sat_lvl", 32'(speed_lvl), exp_lvl[p]);
    end
    check("sat_cnt_max", 32'(cnt_max), 6249);

    // Simultaneous up and down at level 2.
    do_reset();
    up_press(25, 25);
    up_press(25, 25);
    p0 = up_pulses; q0 = dn_pulses;
    key_up = 1'b0; key_dn = 1'b0;
    run_count(25, s, at);
    key_up = 1'b1; key_dn = 1'b1;
    run_count(25, s2, at2);
    check("both_strobes", s + s2, 0);
    check("both_lvl", 32'(speed_lvl), 2);
    check("both_up_pulse", up_pulses - p0, 1);
    check("both_dn_pulse", dn_pulses - q0, 1);

    // Reset in the middle of a key_dn debounce, key stays held.
    do_reset();
    up_press(25, 25);
    up_press(25, 25);
    check("pre_abort_lvl", 32'(speed_lvl), 2);
    q0 = dn_pulses;
    key_dn = 1'b0;
    tick(13);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("abort_lvl", 32'(speed_lvl), 0);
    check("abort_cnt_max", 32'(cnt_max), 49999);
    check("abort_no_pulse", dn_pulses - q0, 0);
    run_count(18, s, at);
    check("refilt_not_yet", dn_pulses - q0, 0);
    run_count(1, s2, at2);
    check("refilt_pulse", dn_pulses - q0, 1);
    check("refilt_strobes", s + s2, 0);
    check("refilt_lvl", 32'(speed_lvl), 0);
    key_dn = 1'b1; tick(30);

    // Long hold, bouncy release, then a second press.
    do_reset();
    p0 = up_pulses;
    key_up = 1'b0; tick(200);
    key_up = 1'b1; tick(1);
    key_up = 1'b0; tick(1);
    key_up = 1'b1; tick(20);
    key_up = 1'b0; tick(30);
    key_up = 1'b1; tick(30);
    check("hold_two_pulses", up_pulses - p0, 2);
    check("hold_lvl", 32'(speed_lvl), 2);

    // Randomized phase against the model.
    do_reset();
    len_up = 0; len_dn = 0;
    for (int c = 0; c < 4000; c++) begin
      if (len_up == 0) begin
        key_up = 1'($urandom_range(0, 1));
        len_up = int'($urandom_range(1, 40));
      end
      if (len_dn == 0) begin
        key_dn = 1'($urandom_range(0, 1));
        len_dn = int'($urandom_range(1, 40));
      end
      rst = ($urandom_range(0, 599) == 0);
      len_up--; len_dn--;
      tick(1);
    end
    rst = 1'b0; key_up = 1'b1; key_dn = 1'b1;
    tick(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
